// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory response controller.
package dmem_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned WADDR_W         = 15;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_wait_cnt.sv
// BUSY-cycle wait counter; o_expire_c flags the last cycle before timeout.
module dmem_wait_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_resp_ctrl.sv
// Data-memory access controller: accepts one LW/SW at a time, drives the
// backing memory, and returns a one-cycle response with a timeout error.
module dmem_resp_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_wr,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack
);

  state_t              r_state;
  logic                r_ready;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;
  logic                r_mem_req;
  logic                r_mem_wr;
  logic [WADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_expire;
  logic w_unused_addr0;

  // Word addressing: the byte-select bit never reaches the memory.
  assign w_unused_addr0 = req_addr[0];

  assign w_cnt_clr = (r_state == IDLE) && req_valid;
  assign w_cnt_en  = (r_state == BUSY) && !mem_ack;

  dmem_wait_cnt #(
    .LIMIT (TIMEOUT)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .o_expire_c (w_expire)
  );

  // The mem_* registers double as the request latches while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state     <= BUSY;
            r_ready     <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_wr    <= req_wr;
            r_mem_addr  <= req_addr[ADDR_W-1:1];
            r_mem_wdata <= req_wdata;
          end
        end
        BUSY: begin
          // An ack always wins over a coincident timeout.
          if (mem_ack || w_expire) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !mem_ack;
            r_resp_rdata <= (mem_ack && !r_mem_wr) ? mem_rdata : '0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Scenario bench for dmem_resp_ctrl; responses are checked against a queue
// of expectations pushed when each request is presented.
module tb_dmem_resp_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_resp   = 0;

  dmem_resp_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk_data(input logic [14:0] a);
    return {a, 1'b0} ^ 16'hC35A;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts acceptances and scores every response pulse.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && req_valid && req_ready) n_accept++;
      if (resp_valid) begin
        n_resp++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: resp rdata=%h err=%b, required no response", resp_rdata, resp_err);
        end else begin
          e = exp_q.pop_front();
          if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_fail++;
            $display("FAIL sb_resp: rdata=%h err=%b, required rdata=%h err=%b", resp_rdata, resp_err, e.rdata, e.err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    n_checks++; if (resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_resp_rdata: got %h required 0000", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
    n_checks++; if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ctl: got req=%b wr=%b required 0 0", mem_req, mem_wr); end
    n_checks++; if (mem_addr !== 15'h0 || mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_bus: got addr=%h wdata=%h required 0 0", mem_addr, mem_wdata); end
    rst = 1'b0;
    cyc();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_load();
    int base = n_resp;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0012; req_wdata = 16'h5555;
    exp_q.push_back(exp_t'{16'hBEEF, 1'b0});
    cyc();
    req_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL load_mem_ctl: got req=%b wr=%b required 1 0", mem_req, mem_wr); end
    n_checks++; if (mem_addr !== 15'h0009) begin n_fail++; $display("FAIL load_mem_addr: got %h required 0009", mem_addr); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_busy_ready: got %b required 0", req_ready); end
    cyc();
    cyc();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    cyc();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL load_resp: got v=%b rdata=%h err=%b required 1 BEEF 0", resp_valid, resp_rdata, resp_err); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_done_mem_req: got %b required 0", mem_req); end
    cyc();
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_after: got v=%b ready=%b required 0 1", resp_valid, req_ready); end
    n_checks++; if (resp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL load_hold_rdata: got %h required BEEF", resp_rdata); end
    cyc();
    n_checks++; if (n_resp - base !== 1) begin n_fail++; $display("FAIL load_pulse_count: got %0d required 1", n_resp - base); end
  endtask

  task automatic test_store();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0021; req_wdata = 16'h1234;
    exp_q.push_back(exp_t'{16'h0000, 1'b0});
    cyc();
    req_valid = 1'b0; req_wr = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin n_fail++; $display("FAIL store_mem_ctl: got req=%b wr=%b required 1 1", mem_req, mem_wr); end
    n_checks++; if (mem_addr !== 15'h0010 || mem_wdata !== 16'h1234) begin
      n_fail++; $display("FAIL store_mem_bus: got addr=%h wdata=%h required 0010 1234", mem_addr, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    cyc();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0000 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL store_resp: got v=%b rdata=%h err=%b required 1 0000 0", resp_valid, resp_rdata, resp_err); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL store_done_mem_wr: got %b required 0", mem_wr); end
    cyc();
  endtask

  task automatic test_timeout();
    int high = 0;
    bit got = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0;
    exp_q.push_back(exp_t'{16'h0000, 1'b1});
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) high++;
      if (resp_valid) begin
        got = 1;
        n_checks++; if (resp_err !== 1'b1 || resp_rdata !== 16'h0000) begin
          n_fail++; $display("FAIL timeout_resp: got err=%b rdata=%h required 1 0000", resp_err, resp_rdata); end
        break;
      end
      cyc();
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL timeout_no_resp: got none within 20 cycles required one"); end
    n_checks++; if (high !== 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d required 4", high); end
    cyc();
  endtask

  task automatic test_ack_at_expiry();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0FF0; req_wdata = 16'h0;
    exp_q.push_back(exp_t'{16'hA5A5, 1'b0});
    cyc();
    req_valid = 1'b0;
    repeat (3) cyc();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL coinc_last_busy: got mem_req=%b required 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    cyc();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'hA5A5) begin
      n_fail++; $display("FAIL coinc_resp: got v=%b err=%b rdata=%h required 1 0 A5A5", resp_valid, resp_err, resp_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    int sent = 0;
    int base_acc = n_accept;
    int base_resp = n_resp;
    bit adv = 0;
    addrs[0] = 16'h0040; addrs[1] = 16'h0102; addrs[2] = 16'h7FFE;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addrs[0]; req_wdata = 16'h1111;
    for (int cy = 0; cy < 40; cy++) begin
      mem_ack   = mem_req;
      mem_rdata = mem_req ? mk_data(mem_addr) : 16'h0;
      if (req_valid && req_ready) begin
        exp_q.push_back(exp_t'{(sent == 1) ? 16'h0000 : mk_data(addrs[sent][15:1]), 1'b0});
        sent++;
        adv = 1;
      end
      cyc();
      if (adv) begin
        adv = 0;
        if (sent == 3) req_valid = 1'b0;
        else begin
          req_addr = addrs[sent]; req_wr = (sent == 1); req_wdata = 16'h1111 + 16'(sent);
        end
      end
      if (sent == 3 && n_resp - base_resp == 3) break;
    end
    mem_ack = 1'b0; mem_rdata = 16'h0; req_wr = 1'b0;
    n_checks++; if (n_accept - base_acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", n_accept - base_acc); end
    n_checks++; if (n_resp - base_resp !== 3) begin n_fail++; $display("FAIL b2b_responses: got %0d required 3", n_resp - base_resp); end
    cyc();
  endtask

  task automatic test_reset_mid_busy();
    int base = n_resp;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0200; req_wdata = 16'h0;
    cyc();
    req_valid = 1'b0;
    cyc();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmb_busy: got mem_req=%b required 1", mem_req); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== 15'h0) begin
      n_fail++; $display("FAIL rmb_mem_drop: got req=%b addr=%h required 0 0", mem_req, mem_addr); end
    cyc();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    cyc();
    cyc();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    n_checks++; if (n_resp !== base || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmb_late_ack: got %0d responses v=%b required 0 0", n_resp - base, resp_valid); end
    n_checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_rdata !== 16'h0) begin
      n_fail++; $display("FAIL rmb_idle: got ready=%b mem_req=%b rdata=%h required 1 0 0000", req_ready, mem_req, resp_rdata); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_ack_at_expiry();
    test_back_to_back();
    test_reset_mid_busy();
    cyc();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_resp_ctrl.md
DMEM_RESP_CTRL -- requirements
Module: dmem_resp_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles to wait for mem_ack (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the pipeline presents an LW/SW request.
REQ-005 SHALL have port req_wr, input, 1 bit: 1 = SW, 0 = LW.
REQ-006 SHALL have port req_addr, input, 16 bits: byte address from the ALU LW/SW path; bit 0 is ignored.
REQ-007 SHALL have port req_wdata, input, 16 bits: store data.
REQ-008 SHALL have port req_ready, output, 1 bit: the controller can accept a request; the pipeline stalls while it is 0.
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 16 bits: load data, qualified by resp_valid.
REQ-011 SHALL have port resp_err, output, 1 bit: the access timed out, qualified by resp_valid.
REQ-012 SHALL have port mem_req, output, 1 bit: request to the backing memory.
REQ-013 SHALL have port mem_wr, output, 1 bit: write strobe to the backing memory.
REQ-014 SHALL have port mem_addr, output, 15 bits: word address (req_addr[15:1]).
REQ-015 SHALL have port mem_wdata, output, 16 bits: write data to the backing memory.
REQ-016 SHALL have port mem_rdata, input, 16 bits: read data, valid with mem_ack.
REQ-017 SHALL have port mem_ack, input, 1 bit: the backing memory has completed the access.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a clock edge.
REQ-020 SHALL, on acceptance, latch req_wr, req_addr[15:1] and req_wdata, move to BUSY, clear the wait counter to 0, and not resample request inputs until the next IDLE.
REQ-021 SHALL drive, in BUSY, mem_req = 1, mem_wr = the latched wr, mem_addr and mem_wdata from the latches; in IDLE and DONE all mem_* outputs SHALL be 0.
REQ-022 SHALL sample mem_ack only in BUSY; mem_ack in IDLE or DONE is ignored.
REQ-023 SHALL, on mem_ack in BUSY, capture mem_rdata for a load (0x0000 for a store), set err = 0, and move to DONE.
REQ-024 SHALL increment the wait counter each BUSY cycle without mem_ack; when the counter equals TIMEOUT-1 with no ack, the next state is DONE with err = 1 and rdata 0x0000.
REQ-025 SHALL give mem_ack priority when mem_ack and timeout expiry coincide (err = 0).
REQ-026 SHALL drive resp_valid = 1 for exactly one cycle in DONE, with registered resp_rdata and resp_err, then return to IDLE unconditionally.
REQ-027 SHALL give minimum latency as follows: accept at edge N, mem_req high in cycle N+1, ack sampled at edge N+2, resp_valid in cycle N+2/N+3, req_ready high again the cycle after resp_valid.
REQ-028 SHALL issue stores to memory with completion signalled by resp_valid; resp_valid also pulses for stores.
REQ-029 SHALL hold resp_rdata and resp_err at their last values outside DONE; they are only meaningful when resp_valid = 1.

Reset
REQ-030 SHALL, on rst = 1 at any time (including mid-BUSY), immediately force state IDLE, counter 0, latches 0, and outputs req_ready = 1 (while rst deasserted), resp_valid = 0, resp_rdata = 0x0000, resp_err = 0, and all mem_* = 0.
REQ-031 SHALL generate no response for an access aborted by reset; a late mem_ack after reset is ignored.

Structure
REQ-032 SHALL place the state encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10) and the default TIMEOUT constant in the shared package dmem_pkg.
REQ-033 SHALL implement the wait counter as the sub-module dmem_wait_cnt (8-bit, with clear, enable and expire outputs).

Verification
REQ-034 SHALL verify a load: addr 0x0012, mem_ack two cycles after mem_req with rdata 0xBEEF -> mem_addr = 0x0009, resp_valid one cycle, resp_rdata = 0xBEEF, resp_err = 0.
REQ-035 SHALL verify a store: addr 0x0021, wdata 0x1234, ack on the first BUSY cycle -> mem_wr = 1, mem_addr = 0x0010, mem_wdata = 0x1234, resp_rdata = 0x0000.
REQ-036 SHALL verify a timeout: TIMEOUT = 4, no ack -> mem_req high exactly 4 cycles, resp_err = 1, resp_rdata = 0x0000.
REQ-037 SHALL verify that req_valid held high across back-to-back requests is accepted only when req_ready = 1, with no request lost or duplicated.
REQ-038 SHALL verify that rst asserted mid-BUSY -> mem_req drops immediately with no resp_valid, and that a following mem_ack is ignored.
REQ-039 SHALL verify that ack and timeout expiry in the same cycle -> resp_err = 0 and the ack data is returned.
